// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Engine-side counterpart of the global phase controller. Decodes the 2-bit
//   phase code, launches the matching engine with a one-cycle start pulse,
//   collects its done strobe (MCMC is relaunched MCMC_ITERS times), and returns
//   a one-cycle finish pulse. A per-launch watchdog forces a finish if an engine
//   hangs.
//
// Ports
//   clk, reset_n                   clock (rising edge), async active-low reset
//   state[1:0]                     phase code: 0 IDLE, 1 PARAM_CALC, 2 MCMC, 3 DCTC
//   param_done / mcmc_iter_done /
//   dctc_done                      engine done strobes
//   param_start / mcmc_start /
//   dctc_start                     one-cycle engine launch pulses
//   param_calc_finish / mcmc_finish /
//   dctc_finish                    one-cycle finish pulses to the global FSM
//   mcmc_iter_cnt[ITER_W-1:0]      completed MCMC iterations in the current phase
//   timeout_err                    sticky: a watchdog expired
//   protocol_err                   sticky: phase code changed mid-operation
module phase_sequencer #(
  parameter int MCMC_ITERS  = 16,
  parameter int ITER_W      = 5,
  parameter int TIMEOUT_CYC = 65535,
  parameter int TO_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        state,
  input  logic              param_done,
  input  logic              mcmc_iter_done,
  input  logic              dctc_done,
  output logic              param_start,
  output logic              mcmc_start,
  output logic              dctc_start,
  output logic              param_calc_finish,
  output logic              mcmc_finish,
  output logic              dctc_finish,
  output logic [ITER_W-1:0] mcmc_iter_cnt,
  output logic              timeout_err,
  output logic              protocol_err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH, S_HOLD} fsm_t;

  localparam logic [1:0]        PH_IDLE  = 2'd0;
  localparam logic [1:0]        PH_PARAM = 2'd1;
  localparam logic [1:0]        PH_MCMC  = 2'd2;
  localparam logic [ITER_W-1:0] ITERS    = ITER_W'(MCMC_ITERS);
  localparam logic [TO_W-1:0]   TO_LIM   = TO_W'(TIMEOUT_CYC);

  fsm_t              fsm_q, fsm_d;
  logic [1:0]        phase_q, phase_d;
  logic [TO_W-1:0]   wd_q, wd_d, wd_inc;
  logic [ITER_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic              te_q, te_d, pe_q, pe_d;
  // one-hot per engine: bit0 param, bit1 mcmc, bit2 dctc
  logic [2:0]        start_q, start_d, fin_q, fin_d;
  logic              done_sel, phase_chg;

  function automatic logic [2:0] ph_onehot(input logic [1:0] ph);
    case (ph)
      2'd1:    ph_onehot = 3'b001;
      2'd2:    ph_onehot = 3'b010;
      2'd3:    ph_onehot = 3'b100;
      default: ph_onehot = 3'b000;
    endcase
  endfunction

  // only the latched phase's done strobe is ever looked at
  always_comb begin
    case (phase_q)
      2'd1:    done_sel = param_done;
      2'd2:    done_sel = mcmc_iter_done;
      2'd3:    done_sel = dctc_done;
      default: done_sel = 1'b0;
    endcase
  end

  assign phase_chg = (state != phase_q);
  // wd_inc counts WAIT cycles including the current one; expiry is the cycle
  // on which it reaches TIMEOUT_CYC, and a done in that same cycle still wins
  assign wd_inc    = wd_q + 1'b1;
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    fsm_d   = fsm_q;
    phase_d = phase_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    te_d    = te_q;
    pe_d    = pe_q;
    start_d = 3'b000;
    fin_d   = 3'b000;
    case (fsm_q)
      S_IDLE: begin
        if (state == PH_IDLE) begin
          phase_d = PH_IDLE;
        end else if (phase_chg) begin
          phase_d = state;
          fsm_d   = S_ISSUE;
          if (state == PH_PARAM) begin
            // a PARAM_CALC entry begins a new core run
            te_d = 1'b0;
            pe_d = 1'b0;
          end
          if (state == PH_MCMC) cnt_d = '0;
        end
      end
      S_ISSUE: begin
        if (phase_chg) begin
          pe_d  = 1'b1;
          fsm_d = S_IDLE;
        end else begin
          start_d = ph_onehot(phase_q);
          wd_d    = '0;
          fsm_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (phase_chg) begin
          pe_d  = 1'b1;
          fsm_d = S_IDLE;
        end else begin
          wd_d = wd_inc;
          if (done_sel) begin
            if (phase_q == PH_MCMC) begin
              cnt_d = cnt_inc;
              fsm_d = (cnt_inc == ITERS) ? S_FINISH : S_ISSUE;
            end else begin
              fsm_d = S_FINISH;
            end
          end else if (wd_inc == TO_LIM) begin
            te_d  = 1'b1;
            fsm_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        fin_d = ph_onehot(phase_q);
        fsm_d = S_HOLD;
      end
      S_HOLD: begin
        if (phase_chg) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= S_IDLE;
      phase_q <= PH_IDLE;
      wd_q    <= '0;
      cnt_q   <= '0;
      te_q    <= 1'b0;
      pe_q    <= 1'b0;
      start_q <= 3'b000;
      fin_q   <= 3'b000;
    end else begin
      fsm_q   <= fsm_d;
      phase_q <= phase_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      te_q    <= te_d;
      pe_q    <= pe_d;
      start_q <= start_d;
      fin_q   <= fin_d;
    end
  end

  assign {dctc_start, mcmc_start, param_start}         = start_q;
  assign {dctc_finish, mcmc_finish, param_calc_finish} = fin_q;
  assign mcmc_iter_cnt = cnt_q;
  assign timeout_err   = te_q;
  assign protocol_err  = pe_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer
//   Directed and randomized scenarios for phase_sequencer. Each scenario is a
//   window of cycles: the phase is presented at relative cycle 3 (after three
//   IDLE cycles). An event-level model computes, from the launch/done timing
//   rules, which start/finish pulses must appear in which cycle, plus the
//   expected iteration count and sticky flags at the end of the window.
//   Done strobes for other phases, and for the latched phase in cycles where
//   the engine is not being waited on, are sprinkled in at random.
module tb_phase_sequencer;
  localparam int MI   = 3;
  localparam int IW   = 3;
  localparam int TO   = 8;
  localparam int TW   = 4;
  localparam int WMAX = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    state = 2'd0;
  logic          param_done = 1'b0, mcmc_iter_done = 1'b0, dctc_done = 1'b0;
  logic          param_start, mcmc_start, dctc_start;
  logic          param_calc_finish, mcmc_finish, dctc_finish;
  logic [IW-1:0] mcmc_iter_cnt;
  logic          timeout_err, protocol_err;
  logic [5:0]    pulses;

  int n_cmp = 0;
  int n_err = 0;

  // reference-model state
  int m_cnt = 0;
  bit m_te = 0, m_pe = 0;

  // per-window stimulus and expected pulses
  bit [1:0] w_state [WMAX];
  bit       w_pd [WMAX], w_md [WMAX], w_dd [WMAX];
  bit [5:0] w_exp [WMAX];

  phase_sequencer #(.MCMC_ITERS(MI), .ITER_W(IW), .TIMEOUT_CYC(TO), .TO_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .state(state),
    .param_done(param_done), .mcmc_iter_done(mcmc_iter_done), .dctc_done(dctc_done),
    .param_start(param_start), .mcmc_start(mcmc_start), .dctc_start(dctc_start),
    .param_calc_finish(param_calc_finish), .mcmc_finish(mcmc_finish),
    .dctc_finish(dctc_finish), .mcmc_iter_cnt(mcmc_iter_cnt),
    .timeout_err(timeout_err), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // bit5 param_start, 4 mcmc_start, 3 dctc_start, 2 param fin, 1 mcmc fin, 0 dctc fin
  assign pulses = {param_start, mcmc_start, dctc_start,
                   param_calc_finish, mcmc_finish, dctc_finish};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [5:0] start_bit(input int ph);
    start_bit = 6'b000001 << (6 - ph);
  endfunction

  function automatic bit [5:0] fin_bit(input int ph);
    fin_bit = 6'b000001 << (3 - ph);
  endfunction

  task automatic set_line(input int l, input int r);
    if (l == 1) w_pd[r] = 1'b1;
    if (l == 2) w_md[r] = 1'b1;
    if (l == 3) w_dd[r] = 1'b1;
  endtask

  task automatic run_window(input int len, input int ph);
    for (int r = 0; r < len; r++) begin
      tick();
      check($sformatf("pulses ph%0d r%0d", ph, r), 32'(pulses), 32'(w_exp[r]));
      state          = w_state[r];
      param_done     = w_pd[r];
      mcmc_iter_done = w_md[r];
      dctc_done      = w_dd[r];
    end
    param_done = 1'b0; mcmc_iter_done = 1'b0; dctc_done = 1'b0;
  endtask

  // ph: 1..3; d[k]: cycles from the k-th start to its done (>= TO means the
  // engine never answers); abort_at >= 0 drops the phase code to 0 there.
  task automatic scenario(input int ph, input int d0, input int d1, input int d2,
                          input int abort_at);
    int  d [3];
    int  s, len, fin, n_it;
    bit  safe [WMAX];
    d   = '{d0, d1, d2};
    fin = 0;
    for (int r = 0; r < WMAX; r++) begin
      w_state[r] = (r >= 3) ? 2'(ph) : 2'd0;
      w_pd[r] = 0; w_md[r] = 0; w_dd[r] = 0; w_exp[r] = '0;
      safe[r] = (r <= 4);
    end
    if (ph == 1) begin m_te = 0; m_pe = 0; end
    if (ph == 2) m_cnt = 0;
    s = 5;
    if (abort_at >= 0) begin
      for (int r = abort_at; r < WMAX; r++) w_state[r] = 2'd0;
      for (int r = abort_at + 1; r < WMAX; r++) safe[r] = 1;
      if (abort_at >= 5) w_exp[5] = start_bit(ph);
      m_pe = 1;
      len  = abort_at + 5;
    end else begin
      n_it = (ph == 2) ? MI : 1;
      for (int k = 0; k < n_it; k++) begin
        w_exp[s] |= start_bit(ph);
        if (d[k] < TO) begin
          set_line(ph, s + d[k]);
          safe[s + d[k] + 1] = 1;
          if (ph == 2) m_cnt++;
          if (k == n_it - 1) begin
            fin = s + d[k] + 2;
            break;
          end
          s = s + d[k] + 2;
        end else begin
          m_te = 1;
          fin  = s + TO + 1;
          break;
        end
      end
      w_exp[fin] |= fin_bit(ph);
      for (int r = fin - 1; r < WMAX; r++) safe[r] = 1;
      len = fin + 4;
    end
    for (int r = 0; r < len - 1; r++)
      for (int l = 1; l <= 3; l++)
        if ((l != ph || safe[r]) && ($urandom % 4 == 0)) set_line(l, r);
    run_window(len, ph);
    check($sformatf("mcmc_iter_cnt ph%0d", ph), 32'(mcmc_iter_cnt), 32'(m_cnt));
    check($sformatf("timeout_err ph%0d", ph), 32'(timeout_err), 32'(m_te));
    check($sformatf("protocol_err ph%0d", ph), 32'(protocol_err), 32'(m_pe));
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    check("reset pulses", 32'(pulses), 32'd0);
    check("reset cnt", 32'(mcmc_iter_cnt), 32'd0);
    check("reset errs", 32'({timeout_err, protocol_err}), 32'd0);
    reset_n = 1'b1;

    // directed
    scenario(1, 5, 0, 0, -1);     // PARAM normal
    scenario(2, 5, 5, 5, -1);     // MCMC, starts 7 apart, cnt 3
    scenario(3, 20, 0, 0, -1);    // DCTC watchdog expiry
    scenario(3, 7, 0, 0, -1);     // done on expiry cycle, timeout_err still sticky
    scenario(1, 2, 0, 0, -1);     // PARAM entry clears sticky flags
    scenario(3, TO - 1, 0, 0, -1);// done on expiry cycle: no error
    scenario(2, 0, 20, 3, -1);    // MCMC timeout on 2nd launch, partial count 1
    scenario(2, 0, 0, 0, 8);      // abort during WAIT
    scenario(1, 0, 0, 0, 4);      // abort during ISSUE: no start at all

    // reset during an MCMC wait
    state = 2'd0;
    repeat (3) tick();
    state = 2'd2;
    tick(); tick();
    check("pre-reset mcmc_start", 32'(mcmc_start), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("async reset pulses", 32'(pulses), 32'd0);
    check("async reset flags", 32'({mcmc_iter_cnt, timeout_err, protocol_err}), 32'd0);
    tick(); tick();
    check("in-reset pulses", 32'(pulses), 32'd0);
    reset_n = 1'b1;
    state   = 2'd1;
    tick();
    check("post-reset +1", 32'(pulses), 32'd0);
    tick();
    check("post-reset +2 start", 32'(pulses), 32'(start_bit(1)));
    param_done = 1'b1;
    tick();
    param_done = 1'b0;
    check("post-reset +3", 32'(pulses), 32'd0);
    tick();
    check("post-reset finish", 32'(pulses), 32'(fin_bit(1)));
    m_te = 0; m_pe = 0; m_cnt = 0;
    tick(); tick();

    // randomized
    for (int i = 0; i < 40; i++) begin
      int ph, ab;
      ph = int'($urandom_range(1, 3));
      ab = ($urandom % 6 == 0) ? int'($urandom_range(4, 11)) : -1;
      scenario(ph, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
               int'($urandom_range(0, 9)), ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Engine-side counterpart of the global phase controller.
- Decodes the controller's 2-bit phase code and issues a one-cycle start pulse to the matching compute engine (parameter calc, MCMC, detection).
- Collects engine done strobes, repeats MCMC for a fixed iteration count, and returns one-cycle finish pulses: param_calc_finish, mcmc_finish, dctc_finish.
- Adds a per-phase watchdog so a hung engine cannot stall the core.

Parameters:
- MCMC_ITERS, 16: MCMC engine launches per MCMC phase (>=1).
- ITER_W, 5: width of the iteration counter; must satisfy 2^ITER_W > MCMC_ITERS.
- TIMEOUT_CYC, 65535: maximum WAIT cycles per engine launch before a forced finish.
- TO_W, 16: watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- state  in  2  phase code from the global FSM: 0 IDLE, 1 PARAM_CALC, 2 MCMC, 3 DCTC.
- param_done  in  1  parameter engine done strobe.
- mcmc_iter_done  in  1  MCMC engine single-iteration done strobe.
- dctc_done  in  1  detection engine done strobe.
- param_start  out  1  one-cycle launch pulse, parameter engine.
- mcmc_start  out  1  one-cycle launch pulse, MCMC engine (one per iteration).
- dctc_start  out  1  one-cycle launch pulse, detection engine.
- param_calc_finish  out  1  one-cycle finish pulse to the global FSM.
- mcmc_finish  out  1  one-cycle finish pulse to the global FSM.
- dctc_finish  out  1  one-cycle finish pulse to the global FSM.
- mcmc_iter_cnt  out  ITER_W  completed MCMC iterations in the current phase.
- timeout_err  out  1  sticky: a watchdog expired.
- protocol_err  out  1  sticky: phase code changed mid-operation.

Behaviour:
- Reset (async, reset_n low): every output is 0; internal FSM is S_IDLE; latched phase is IDLE; iteration and watchdog counters are 0.
- All outputs are registered.
- Internal FSM states: S_IDLE, S_ISSUE, S_WAIT, S_FINISH, S_HOLD.
- S_IDLE: when state is non-zero and differs from the latched phase, latch the phase and go to S_ISSUE. If state is 0, clear the latched phase.
- S_ISSUE: assert the latched phase's start output for exactly one cycle, clear the watchdog, go to S_WAIT.
- S_WAIT: the watchdog increments each cycle. The done input of the latched phase is the only one honoured.
  - PARAM_CALC or DCTC: done goes to S_FINISH.
  - MCMC: done increments mcmc_iter_cnt. If the new count equals MCMC_ITERS, go to S_FINISH; otherwise go to S_ISSUE to relaunch.
- S_FINISH: assert the latched phase's finish output for exactly one cycle, then go to S_HOLD.
- S_HOLD: wait until state differs from the latched phase, then go to S_IDLE. The new phase is detected from S_IDLE on the following cycle.
- Latency:
  - Phase visible in cycle t: start is high in t+2.
  - Done high in cycle d: finish is high in d+2.
  - Back-to-back MCMC iterations: done in d gives mcmc_start in d+2.
- mcmc_iter_cnt: cleared on entry to S_ISSUE from S_IDLE for the MCMC phase. It holds its value through S_HOLD and S_IDLE until the next MCMC entry.
- Watchdog: if the watchdog reaches TIMEOUT_CYC in S_WAIT without done, set timeout_err and go to S_FINISH. For MCMC this terminates the remaining iterations, and mcmc_iter_cnt keeps its partial value.
- Done and watchdog expiry in the same cycle: done wins and timeout_err is not set.
- Spurious done strobes (outside S_WAIT, or for a non-latched phase) are ignored, with no error.
- Simultaneous done strobes: only the latched phase's strobe counts.
- Phase change mid-operation: if in S_ISSUE or S_WAIT the state differs from the latched phase, abort. Set protocol_err, suppress the finish pulse, go to S_IDLE. Any start pulse already issued is not retracted.
- Sticky flags (timeout_err, protocol_err) clear only on reset or on a fresh entry into PARAM_CALC, which starts a new core run.
- Reset mid-operation: outputs drop to 0 immediately. After reset release, a non-zero state is treated as a new entry.
- The counters never wrap under the parameter constraints.

Test Plan:
- PARAM phase: state 0 to 1 at cycle 10; param_done at cycle 20 -> param_start high at cycle 12 only; param_calc_finish high at cycle 22 only; no errors.
- MCMC, MCMC_ITERS=3: state=2; each mcmc_iter_done sent 5 cycles after its start -> exactly 3 mcmc_start pulses spaced 7 cycles apart; mcmc_finish one cycle after the 3rd done is registered; mcmc_iter_cnt=3.
- Watchdog, TIMEOUT_CYC=8: state=3 with no dctc_done -> dctc_finish 1 pulse; timeout_err=1 and stays 1 through an IDLE return. The next PARAM_CALC entry clears it.
- Done at the expiry cycle, TIMEOUT_CYC=8: dctc_done exactly when the watchdog reaches 8 -> normal dctc_finish; timeout_err=0.
- Spurious and crossed strobes: param_done and dctc_done pulsed while in the MCMC phase, and mcmc_iter_done while IDLE -> no count change; no finish; no start.
- Abort and reset: state forced 2 to 0 during S_WAIT -> protocol_err=1, no mcmc_finish. Separately, reset_n low during S_WAIT -> all outputs 0 asynchronously. After release with state=1, param_start fires 2 cycles later.
